// File: rtl/muldiv_seq_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_seq_if : request/response bundle between EX and the mul/div sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic                start_i;
  logic [2:0]          op_i;
  logic [XLEN-1:0]     op_a_i;
  logic [XLEN-1:0]     op_b_i;
  logic                flush_i;
  logic                busy_o;
  logic                done_o;
  logic [2*XLEN-1:0]   result_o;

  modport master (
    output start_i, op_i, op_a_i, op_b_i, flush_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, op_a_i, op_b_i, flush_i,
    output busy_o, done_o, result_o
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_seq : iterative RV32M multiply/divide (shift-add / restoring divide)
// Revision: 1.0
// ---------------------------------------------------------------------------
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state;
  state_t              next_state;
  logic [2:0]          op;
  logic [XLEN-1:0]     a_reg;
  logic [XLEN-1:0]     b_reg;
  logic [XLEN:0]       acc;
  logic [XLEN-1:0]     lo;
  logic                neg;
  logic [CNT_W-1:0]    cnt;
  logic [2*XLEN-1:0]   result;
  logic                busy;
  logic                done;

  // Request decode while idle
  logic                accept;
  logic                in_is_rem;
  logic                div_zero;
  logic                div_ovf;
  logic                special;
  logic [2*XLEN-1:0]   special_res;

  assign accept    = bus.start_i & ~bus.flush_i;
  assign in_is_rem = bus.op_i[2] & bus.op_i[1];
  assign div_zero  = bus.op_i[2] & (bus.op_b_i == '0);
  assign div_ovf   = ((bus.op_i == OP_DIV) | (bus.op_i == OP_REM)) &
                     (bus.op_a_i == MIN_NEG) & (bus.op_b_i == '1);
  assign special   = div_zero | div_ovf;

  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res[XLEN-1:0] = in_is_rem ? bus.op_a_i : '1;
    end else begin
      special_res[XLEN-1:0] = in_is_rem ? '0 : MIN_NEG;
    end
  end

  // Operand conditioning for the latched op
  logic                is_div;
  logic                is_rem;
  logic                a_signed;
  logic                b_signed;
  logic                sa;
  logic                sb;
  logic [XLEN-1:0]     abs_a;
  logic [XLEN-1:0]     abs_b;

  assign is_div   = op[2];
  assign is_rem   = op[2] & op[1];
  assign a_signed = (op == OP_MULH) | (op == OP_MULHSU) | (op == OP_DIV) | (op == OP_REM);
  assign b_signed = (op == OP_MULH) | (op == OP_DIV) | (op == OP_REM);
  assign sa       = a_signed & a_reg[XLEN-1];
  assign sb       = b_signed & b_reg[XLEN-1];
  assign abs_a    = sa ? (~a_reg + 1'b1) : a_reg;
  assign abs_b    = sb ? (~b_reg + 1'b1) : b_reg;

  // One iteration of each algorithm; the extra bit carries add-out / borrow
  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_shift;
  logic [XLEN:0]       div_diff;

  assign mul_sum   = acc + {1'b0, (lo[0] ? a_reg : '0)};
  assign div_shift = {acc[XLEN-1:0], lo[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, b_reg};

  logic [2*XLEN-1:0]   prod;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quot_fix;
  logic [XLEN-1:0]     rem_fix;
  logic [2*XLEN-1:0]   fix_res;

  assign prod     = {acc[XLEN-1:0], lo};
  assign prod_fix = neg ? (~prod + 1'b1) : prod;
  assign quot_fix = neg ? (~lo + 1'b1) : lo;
  assign rem_fix  = neg ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];

  always_comb begin
    fix_res = prod_fix;
    if (is_div) begin
      fix_res = {{XLEN{1'b0}}, (is_rem ? rem_fix : quot_fix)};
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (accept) next_state = special ? S_DONE : S_PREP;
      S_PREP: next_state = S_CALC;
      S_CALC: if (cnt == LAST_CNT) next_state = S_FIX;
      S_FIX:  next_state = S_DONE;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if ((state != S_IDLE) && bus.flush_i) begin
      next_state = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      op     <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      acc    <= '0;
      lo     <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      busy <= (next_state == S_PREP) | (next_state == S_CALC) | (next_state == S_FIX);
      done <= (next_state == S_DONE);
      case (state)
        S_IDLE: begin
          if (accept) begin
            op    <= bus.op_i;
            a_reg <= bus.op_a_i;
            b_reg <= bus.op_b_i;
            if (special) result <= special_res;
          end
        end
        S_PREP: begin
          // Multiply: a_reg = multiplicand, lo = multiplier.
          // Divide:   lo = dividend shifting into quotient, b_reg = divisor.
          acc   <= '0;
          cnt   <= '0;
          neg   <= is_rem ? sa : (sa ^ sb);
          a_reg <= abs_a;
          b_reg <= abs_b;
          lo    <= is_div ? abs_a : abs_b;
        end
        S_CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            if (!div_diff[XLEN]) begin
              acc <= div_diff;
              lo  <= {lo[XLEN-2:0], 1'b1};
            end else begin
              acc <= div_shift;
              lo  <= {lo[XLEN-2:0], 1'b0};
            end
          end else begin
            acc <= {1'b0, mul_sum[XLEN:1]};
            lo  <= {mul_sum[0], lo[XLEN-1:1]};
          end
        end
        S_FIX: begin
          if (!bus.flush_i) result <= fix_res;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o   = busy;
  assign bus.done_o   = done;
  assign bus.result_o = result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_muldiv_seq : directed self-checking bench for muldiv_seq
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_muldiv_seq;
  localparam int XLEN = 32;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  muldiv_seq_if #(.XLEN(XLEN)) bus ();

  muldiv_seq #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int overlap  = 0;

  always @(negedge clk) begin
    if (bus.busy_o && bus.done_o) overlap++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue a one-cycle start; returns in cycle T+1, then scrambles operands
  task automatic drive_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.op_a_i  = a;
    bus.op_b_i  = b;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.op_a_i  = $urandom;
    bus.op_b_i  = $urandom;
  endtask

  task automatic wait_done(input int inject_at, output int lat, output int busy_cnt,
                           output logic got_done);
    lat      = 1;
    busy_cnt = 0;
    got_done = 1'b0;
    while (lat <= 60) begin
      if (bus.done_o) begin
        got_done = 1'b1;
        break;
      end
      if (bus.busy_o) busy_cnt++;
      if (lat == inject_at) begin
        bus.start_i = 1'b1;
        bus.op_i    = OP_MUL;
        bus.op_a_i  = 32'd9;
        bus.op_b_i  = 32'd9;
      end else begin
        bus.start_i = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start_i = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res,
                        input int inject_at);
    int   lat;
    int   busy_cnt;
    logic got_done;
    drive_start(op, a, b);
    wait_done(inject_at, lat, busy_cnt, got_done);
    check({tag, "_done"}, 64'(got_done), 64'd1);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy"}, 64'(busy_cnt), 64'(exp_lat - 1));
    check({tag, "_res"}, bus.result_o, exp_res);
    @(negedge clk);
    check({tag, "_pulse"}, {62'd0, bus.busy_o, bus.done_o}, 64'd0);
  endtask

  task automatic watch_idle(input string tag, input int n);
    int act = 0;
    repeat (n) begin
      if (bus.busy_o || bus.done_o) act++;
      @(negedge clk);
    end
    check(tag, 64'(act), 64'd0);
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.op_i    = '0;
    bus.op_a_i  = '0;
    bus.op_b_i  = '0;
    repeat (3) @(negedge clk);
    check("reset_outs", {bus.result_o[61:0], bus.busy_o, bus.done_o}, 64'd0);
    check("reset_res", bus.result_o, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    run_op("divu",      OP_DIVU,   32'd100,        32'd7,          35, 64'd14,                  0);
    run_op("remu",      OP_REMU,   32'd100,        32'd7,          35, 64'd2,                   0);
    run_op("div_neg",   OP_DIV,    32'hFFFF_FFF9,  32'd2,          35, 64'h0000_0000_FFFF_FFFD, 0);
    run_op("rem_neg",   OP_REM,    32'hFFFF_FFF9,  32'd2,          35, 64'h0000_0000_FFFF_FFFF, 0);
    run_op("divu_z",    OP_DIVU,   32'h0000_1234,  32'd0,          1,  64'h0000_0000_FFFF_FFFF, 0);
    run_op("remu_z",    OP_REMU,   32'h0000_1234,  32'd0,          1,  64'h0000_0000_0000_1234, 0);
    run_op("div_ovf",   OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  1,  64'h0000_0000_8000_0000, 0);
    run_op("rem_ovf",   OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  1,  64'd0,                   0);
    run_op("mulh",      OP_MULH,   32'h8000_0000,  32'h8000_0000,  35, 64'h4000_0000_0000_0000, 0);
    run_op("mulhsu",    OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  35, 64'hFFFF_FFFF_0000_0001, 0);
    run_op("mulhu",     OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  35, 64'hFFFF_FFFE_0000_0001, 0);
    run_op("mul",       OP_MUL,    32'd3,          32'd5,          35, 64'd15,                  0);

    // Flush mid-divide: no completion, previous result retained
    drive_start(OP_DIVU, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    check("flush_busy", 64'(bus.busy_o), 64'd0);
    watch_idle("flush_quiet", 40);
    check("flush_res", bus.result_o, 64'd15);
    run_op("after_flush", OP_DIVU, 32'd1000, 32'd3, 35, 64'd333, 0);

    // Start while busy is ignored
    run_op("inject", OP_DIVU, 32'd50, 32'd5, 35, 64'd10, 5);
    watch_idle("inject_quiet", 40);

    // Reset mid-operation
    drive_start(OP_MULHU, 32'hFFFF_FFFF, 32'h2);
    repeat (19) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_flags", {62'd0, bus.busy_o, bus.done_o}, 64'd0);
    check("rst_mid_res", bus.result_o, 64'd0);
    rst = 1'b1;
    watch_idle("rst_quiet", 40);

    // Flush and start together in IDLE
    bus.start_i = 1'b1;
    bus.flush_i = 1'b1;
    bus.op_i    = OP_DIVU;
    bus.op_a_i  = 32'd8;
    bus.op_b_i  = 32'd0;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    watch_idle("flush_start", 40);

    check("busy_done_overlap", 64'(overlap), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer serving the RV32M ops of the EX stage (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Accepts one operation per start pulse and runs a 32-step shift-add multiply or restoring divide.
- Holds the pipeline via busy_o and returns a 64-bit result aligned to the ALU result bus; EX selects [31:0] or [63:32].
- Jump flushes abort an in-flight operation.

Parameters:
- XLEN, 32, operand width; fixes the iteration count at XLEN.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-low (0 = reset, sampled on clk rising edge).
- start_i  input  1  request strobe; sampled only in IDLE.
- op_i  input  3  0=MUL 1=MULH 2=MULHSU 3=MULHU 4=DIV 5=DIVU 6=REM 7=REMU; sampled with start_i.
- op_a_i  input  XLEN  rs1 value; multiplicand or dividend.
- op_b_i  input  XLEN  rs2 value; multiplier or divisor.
- flush_i  input  1  abort from ctrl on jump_flag.
- busy_o  output  1  operation in flight; ctrl stalls IF/ID/EX while high.
- done_o  output  1  one-cycle pulse; result_o is valid this cycle.
- result_o  output  2*XLEN  MUL*: full product. DIV*: {0, quotient}. REM*: {0, remainder}.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, busy_o=0, done_o=0, result_o=0, counter=0, internal regs=0. Overrides start_i and flush_i, including mid-operation.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE, start_i=1, flush_i=0: latch op and operands, then:
  - DIV*/REM* with op_b_i=0 → DONE next cycle. Quotient = all ones; remainder = op_a_i.
  - DIV/REM with op_a_i=0x80000000 and op_b_i=0xFFFFFFFF → DONE next cycle. Quotient = 0x80000000; remainder = 0.
  - Otherwise → PREP.
- PREP (1 cycle):
  - Take absolute values of signed operands: MULH both; MULHSU op_a only; DIV/REM both. MUL, MULHU, DIVU and REMU are unsigned.
  - Record result sign: product sign = sa^sb. Quotient sign = sa^sb. Remainder sign = sa.
  - Clear counter. → CALC.
- CALC (XLEN cycles, counter 0..XLEN-1):
  - Multiply: if multiplier LSB set, add multiplicand into the upper accumulator; shift {acc, mplier} right 1 with carry-in.
  - Divide: shift {rem, quot} left 1; trial-subtract the divisor from rem; if no borrow, commit and set quot LSB=1.
  - Counter=XLEN-1 → FIX.
- FIX (1 cycle): two's-complement negate the product/quotient/remainder when its recorded sign is 1. Write result_o. → DONE.
- DONE (1 cycle): done_o=1, busy_o=0. → IDLE.
- Latency: start sampled at edge T. Normal op: done_o high in cycle T+XLEN+3 (T+35). Special divide case: done_o high at T+1.
- busy_o=1 exactly in PREP, CALC and FIX. It is registered, so ctrl must stall on (start_i & ~busy_o) | busy_o.
- done_o is never asserted together with busy_o.
- result_o updates only on entry to DONE and holds its value until the next completion.
- start_i outside IDLE (including the DONE cycle) is ignored; no queueing.
- flush_i=1 in any non-IDLE state: → IDLE at the next edge, busy_o=0, no done_o pulse, result_o unchanged.
- flush_i and start_i together in IDLE: flush wins and the operation is not accepted.
- Operand inputs may change after the start cycle without effect.
- All arithmetic is modulo 2^(2*XLEN). The accumulator is XLEN+1 bits to capture the add carry and the subtract borrow.

Test Plan:
- DIVU a=100 b=7 → done_o at T+35, result_o[31:0]=14. Repeat as REMU → 2. busy_o high T+1..T+34.
- DIV a=-7 (0xFFFFFFF9) b=2 → 0xFFFFFFFD. REM with same operands → 0xFFFFFFFF.
- DIVU a=0x1234 b=0 → done at T+1, result 0xFFFFFFFF. REMU same → 0x1234. DIV 0x80000000/0xFFFFFFFF → 0x80000000 at T+1. REM same → 0.
- MULH 0x80000000×0x80000000 → result_o=0x4000000000000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF00000001. MULHU same operands → 0xFFFFFFFE00000001. MUL 3×5 → [31:0]=15.
- Start DIVU, flush_i at T+10 → IDLE at T+11, no done_o, result_o keeps previous value. New start at T+12 completes normally at T+47.
- start_i pulsed at T+5 during busy → ignored, single done_o at T+35. rst=0 at T+20 → all outputs 0 next edge. flush_i+start_i together in IDLE → busy_o stays 0.
